// File: rtl/delay_diff_ctrl_if.sv
// Config port for delay_diff_ctrl: valid/ready request plus an error pulse.
interface delay_diff_ctrl_if #(parameter int DELAY_W = 7);
  logic               cfg_valid;
  logic [DELAY_W-1:0] cfg_delay;
  logic               cfg_ready;
  logic               cfg_err;

  modport master (output cfg_valid, cfg_delay, input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_delay, output cfg_ready, cfg_err);
endinterface

// File: rtl/delay_diff_ctrl.sv
// Owns delay_sel for the delay-difference datapath, defers config commits to
// safe points, and qualifies datapath output against history fill state.
module delay_diff_ctrl #(
  parameter int DELAY_W       = 7,
  parameter int MIN_DELAY     = 1,
  parameter int MAX_DELAY     = 64,
  parameter int DEFAULT_DELAY = 8,
  parameter int PIPE_LAT      = 3   // must be >= 2
) (
  input  logic               clk,
  input  logic               rst_n,
  delay_diff_ctrl_if.slave   cfg,
  input  logic               sync_in,
  input  logic               valid_in,
  input  logic               dp_valid_out,
  output logic [DELAY_W-1:0] delay_sel,
  output logic               out_enable,
  output logic               locked,
  input  logic               blank_clr,
  output logic [15:0]        blank_cnt
);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t              state;
  logic                pending;
  logic [DELAY_W-1:0]  shadow;
  logic                err_q;
  logic [2:0]          run_cnt;
  logic [PIPE_LAT-1:0] tag_pipe;

  logic               accept, in_range, commit, hist_ok;
  logic [DELAY_W:0]   need_sum;
  logic [DELAY_W-4:0] need;

  assign accept   = cfg.cfg_valid & ~pending;
  assign in_range = (int'(cfg.cfg_delay) >= MIN_DELAY) && (int'(cfg.cfg_delay) <= MAX_DELAY);
  // accept requires !pending, so accept and commit can never share an edge
  assign commit   = pending & (sync_in | ~valid_in);

  // columns of 16 samples needed to cover the selected delay: ceil(N/16)
  assign need_sum = {1'b0, delay_sel} + (DELAY_W+1)'(15);
  assign need     = need_sum[DELAY_W:4];
  assign hist_ok  = (DELAY_W-3)'(run_cnt) >= need;

  assign cfg.cfg_ready = ~pending;
  assign cfg.cfg_err   = err_q;
  assign locked        = (state == RUN);
  assign out_enable    = dp_valid_out & tag_pipe[PIPE_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_sel <= DELAY_W'(DEFAULT_DELAY);
      shadow    <= '0;
      pending   <= 1'b0;
      err_q     <= 1'b0;
      run_cnt   <= '0;
      tag_pipe  <= '0;
      state     <= FILL;
      blank_cnt <= '0;
    end else begin
      err_q <= accept & ~in_range;
      if (accept && in_range) begin
        shadow  <= cfg.cfg_delay;
        pending <= 1'b1;
      end else if (commit) begin
        delay_sel <= shadow;
        pending   <= 1'b0;
      end

      // any gap invalidates history since the datapath shifts every clock
      if (!valid_in)          run_cnt <= '0;
      else if (run_cnt < 3'd4) run_cnt <= run_cnt + 3'd1;

      tag_pipe <= {tag_pipe[PIPE_LAT-2:0], valid_in & hist_ok};
      state    <= hist_ok ? RUN : FILL;

      if (blank_clr)
        blank_cnt <= '0;
      else if (dp_valid_out && !tag_pipe[PIPE_LAT-1] && blank_cnt != 16'hFFFF)
        blank_cnt <= blank_cnt + 16'd1;
    end
  end

endmodule
